// File: rtl/truth_table_bist4_pkg.sv
// Shared types and sizing for the 4-input truth-table BIST engine.
package bist4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int VEC_N    = 16;
    localparam int IDX_W    = 4;
    localparam int ERR_W    = 5;
    localparam int SETTLE_W = 4;

    localparam logic [IDX_W-1:0] IDX_LAST = 4'd15;

    // Expected response for one vector of a packed truth table.
    function automatic logic expected_bit(input logic [VEC_N-1:0] table_v,
                                          input logic [IDX_W-1:0] idx_v);
        return table_v[idx_v];
    endfunction

endpackage

// File: rtl/truth_table_bist4_if.sv
// Bundle of stimulus, response and result signals between a host and the BIST engine.
interface truth_table_bist4_if;

    logic                         start;
    logic                         a;
    logic                         b;
    logic                         c;
    logic                         d;
    logic                         y;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic [bist4_pkg::ERR_W-1:0]  err_count;
    logic                         first_fail_valid;
    logic [bist4_pkg::IDX_W-1:0]  first_fail_idx;

    modport master (
        output start,
        output y,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_valid,
        input  first_fail_idx
    );

    modport slave (
        input  start,
        input  y,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_valid,
        output first_fail_idx
    );

endinterface

// File: rtl/truth_table_bist4_settle_timer.sv
// Loadable down-counter that paces how long each vector is held before sampling.
module settle_timer
    import bist4_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_r;

    // Counter register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {SETTLE_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {SETTLE_W{1'b0}})) begin
            count_r <= count_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {SETTLE_W{1'b0}});

endmodule

// File: rtl/truth_table_bist4.sv
// On-chip stimulus/response engine: walks all 16 vectors of a 4-input block and
// compares its output against a fixed expected truth table.
module truth_table_bist4
    import bist4_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE   = 16'h0000,
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    truth_table_bist4_if.slave bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

    state_t             state_r,  state_nxt_s;
    logic [IDX_W-1:0]   idx_r,    idx_nxt_s;
    logic [IDX_W-1:0]   vec_r,    vec_nxt_s;
    logic               busy_r,   busy_nxt_s;
    logic               done_r,   done_nxt_s;
    logic               pass_r,   pass_nxt_s;
    logic [ERR_W-1:0]   err_r,    err_nxt_s;
    logic               ffv_r,    ffv_nxt_s;
    logic [IDX_W-1:0]   ffi_r,    ffi_nxt_s;
    logic               miss_s;
    logic               tmr_load_s;
    logic               tmr_en_s;
    logic               tmr_zero_s;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (SETTLE_LD),
        .en       (tmr_en_s),
        .zero     (tmr_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic; a start arriving on the final sample edge is ignored.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        vec_nxt_s   = vec_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = done_r;
        err_nxt_s   = err_r;
        ffv_nxt_s   = ffv_r;
        ffi_nxt_s   = ffi_r;
        tmr_load_s  = 1'b0;
        tmr_en_s    = 1'b0;
        miss_s      = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    vec_nxt_s   = {IDX_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                    done_nxt_s  = 1'b0;
                    err_nxt_s   = {ERR_W{1'b0}};
                    ffv_nxt_s   = 1'b0;
                    ffi_nxt_s   = {IDX_W{1'b0}};
                    tmr_load_s  = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (tmr_zero_s) begin
                    miss_s = bus.y ^ expected_bit(TRUTH_TABLE, idx_r);
                    if (miss_s) begin
                        err_nxt_s = err_r + {{(ERR_W-1){1'b0}}, 1'b1};
                        if (!ffv_r) begin
                            ffv_nxt_s = 1'b1;
                            ffi_nxt_s = idx_r;
                        end else begin
                            ffv_nxt_s = ffv_r;
                        end
                    end else begin
                        err_nxt_s = err_r;
                    end
                    if (idx_r != IDX_LAST) begin
                        idx_nxt_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        vec_nxt_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        tmr_load_s = 1'b1;
                    end else begin
                        state_nxt_s = DONE;
                        vec_nxt_s   = {IDX_W{1'b0}};
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = {IDX_W{1'b0}};
                vec_nxt_s   = {IDX_W{1'b0}};
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
                err_nxt_s   = {ERR_W{1'b0}};
                ffv_nxt_s   = 1'b0;
                ffi_nxt_s   = {IDX_W{1'b0}};
            end
        endcase

        pass_nxt_s = done_nxt_s & (err_nxt_s == {ERR_W{1'b0}});
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= {IDX_W{1'b0}};
            vec_r  <= {IDX_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= {ERR_W{1'b0}};
            ffv_r  <= 1'b0;
            ffi_r  <= {IDX_W{1'b0}};
        end else begin
            idx_r  <= idx_nxt_s;
            vec_r  <= vec_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            pass_r <= pass_nxt_s;
            err_r  <= err_nxt_s;
            ffv_r  <= ffv_nxt_s;
            ffi_r  <= ffi_nxt_s;
        end
    end

    assign bus.a                = vec_r[3];
    assign bus.b                = vec_r[2];
    assign bus.c                = vec_r[1];
    assign bus.d                = vec_r[0];
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.pass             = pass_r;
    assign bus.err_count        = err_r;
    assign bus.first_fail_valid = ffv_r;
    assign bus.first_fail_idx   = ffi_r;

endmodule

// File: tb/tb_truth_table_bist4.sv
// Randomized bench for truth_table_bist4: two instances (settle 0 and 3) driven by a
// fault-injecting model of the block under test, checked against a popcount/ordering model.
module tb_truth_table_bist4;

    logic clk;
    logic rst_n;

    truth_table_bist4_if bus0 ();
    truth_table_bist4_if bus1 ();

    truth_table_bist4 #(.TRUTH_TABLE(16'hA5F0), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    truth_table_bist4 #(.TRUTH_TABLE(16'hA5F0), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [15:0] tt_v;
    logic [15:0] mask_v [2];
    logic        start_v [2];
    logic [3:0]  vec_v [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic        pass_v [2];
    logic [4:0]  err_v [2];
    logic        ffv_v [2];
    logic [3:0]  ffi_v [2];

    int checks;
    int failures;

    assign vec_v[0]  = {bus0.a, bus0.b, bus0.c, bus0.d};
    assign vec_v[1]  = {bus1.a, bus1.b, bus1.c, bus1.d};
    assign busy_v[0] = bus0.busy;
    assign busy_v[1] = bus1.busy;
    assign done_v[0] = bus0.done;
    assign done_v[1] = bus1.done;
    assign pass_v[0] = bus0.pass;
    assign pass_v[1] = bus1.pass;
    assign err_v[0]  = bus0.err_count;
    assign err_v[1]  = bus1.err_count;
    assign ffv_v[0]  = bus0.first_fail_valid;
    assign ffv_v[1]  = bus1.first_fail_valid;
    assign ffi_v[0]  = bus0.first_fail_idx;
    assign ffi_v[1]  = bus1.first_fail_idx;
    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    // Block under test: golden response with selected vectors inverted.
    assign bus0.y = tt_v[vec_v[0]] ^ mask_v[0][vec_v[0]];
    assign bus1.y = tt_v[vec_v[1]] ^ mask_v[1][vec_v[1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int w, input string tag);
        check_eq({tag, "_vec"},  int'(vec_v[w]),  0);
        check_eq({tag, "_busy"}, int'(busy_v[w]), 0);
        check_eq({tag, "_done"}, int'(done_v[w]), 0);
        check_eq({tag, "_pass"}, int'(pass_v[w]), 0);
        check_eq({tag, "_err"},  int'(err_v[w]),  0);
        check_eq({tag, "_ffv"},  int'(ffv_v[w]),  0);
        check_eq({tag, "_ffi"},  int'(ffi_v[w]),  0);
    endtask

    // One full run; poke_t >= 0 pulses start at that cycle offset while running.
    task automatic do_run(input int w, input logic [15:0] mask, input int poke_t);
        int settle, exp_len, t, hold_err, exp_err, exp_ffi;
        logic [4:0] err_keep;
        settle  = (w == 0) ? 0 : 3;
        exp_len = 16 * (settle + 1);
        exp_err = 0;
        exp_ffi = -1;
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) begin
                exp_err++;
                if (exp_ffi < 0) exp_ffi = k;
            end
        end
        mask_v[w] = mask;
        @(negedge clk);
        start_v[w] = 1'b1;
        @(negedge clk);
        start_v[w] = 1'b0;
        t = 0;
        hold_err = 0;
        while (!done_v[w] && t < exp_len + 8) begin
            if (vec_v[w] != 4'(t / (settle + 1)) || !busy_v[w]) hold_err++;
            start_v[w] = (t == poke_t);
            @(negedge clk);
            t++;
        end
        start_v[w] = 1'b0;
        check_eq("run_len",  t, exp_len);
        check_eq("hold_seq", hold_err, 0);
        check_eq("done",     int'(done_v[w]), 1);
        check_eq("busy_end", int'(busy_v[w]), 0);
        check_eq("vec_end",  int'(vec_v[w]), 0);
        check_eq("err",      int'(err_v[w]), exp_err);
        check_eq("pass",     int'(pass_v[w]), (exp_err == 0) ? 1 : 0);
        check_eq("ffv",      int'(ffv_v[w]), (exp_err != 0) ? 1 : 0);
        if (exp_err != 0) check_eq("ffi", int'(ffi_v[w]), exp_ffi);
        // Results must hold in DONE even as the response changes.
        err_keep = err_v[w];
        mask_v[w] = ~mask;
        repeat (3) @(negedge clk);
        check_eq("done_hold", int'(done_v[w]), 1);
        check_eq("err_hold",  int'(err_v[w]), int'(err_keep));
        check_eq("busy_hold", int'(busy_v[w]), 0);
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        tt_v      = 16'hA5F0;
        mask_v[0] = 16'h0000;
        mask_v[1] = 16'h0000;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);

        do_run(0, 16'h0000, -1);          // golden
        do_run(0, 16'hFFFF, -1);          // inverted response
        do_run(1, 16'h0200, -1);          // single fault at vector 9, settle 3
        do_run(0, 16'h0000, 5);           // start ignored at vector 5
        do_run(1, 16'h0041, 5 * 4 + 1);   // same with settle 3
        do_run(0, 16'h1300, 15);          // start on the final sample edge
        do_run(1, 16'h8000, 63);

        // Reset while vector 7 is on the bus.
        mask_v[0] = 16'($urandom);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (vec_v[0] != 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_vec7", int'(vec_v[0]), 7);
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0, "postrst");
        do_run(0, 16'h0000, -1);

        // Failing run followed by a restart from DONE with the model fixed.
        do_run(1, 16'h0C30, -1);
        do_run(1, 16'h0000, -1);

        for (int i = 0; i < 6; i++) begin
            int w;
            logic [15:0] m;
            w = int'($urandom_range(1, 0));
            m = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
            do_run(w, m, ($urandom_range(1, 0) == 1) ? (w == 0 ? 15 : 63) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_bist4.md
Name: truth_table_bist4

Overview:
- Synthesizable stimulus/response engine for 4-input, 1-output combinational blocks.
- On `start`, drives all 16 input vectors onto a, b, c, d in ascending order.
- After a programmable settle time, samples the DUT output y and compares it against a parameterised expected truth table.
- Reports mismatch count, first failing vector and a pass flag. Replaces simulation-only stimulus with an on-chip self-check.

Parameters:
- TRUTH_TABLE, 16'h0000, expected y per vector; bit k is the expected y when {a,b,c,d} == k (a is the MSB).
- SETTLE_CYCLES, 0, extra cycles each vector is held before sampling. Legal range 0..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a run; only sampled in IDLE or DONE.
- a  output  1  stimulus bit 3 (MSB of vector index).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus bit 0.
- y  input  1  DUT response; treated as combinational from a..d.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  5  number of mismatching vectors, 0..16.
- first_fail_valid  output  1  high once any mismatch has been seen in the current run.
- first_fail_idx  output  4  index of the first mismatching vector; valid only when first_fail_valid is high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State is IDLE.
  - a, b, c, d, busy, done, pass, err_count, first_fail_valid and first_fail_idx are all 0.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Next cycle: state RUN, busy=1, done=0.
  - idx=0, so {a,b,c,d}=0000.
  - err_count and first_fail are cleared.
  - Settle counter loaded with SETTLE_CYCLES.
- RUN, per vector:
  - The vector is held for SETTLE_CYCLES+1 cycles.
  - On each clock edge where the settle counter is nonzero, the counter decrements.
  - On the edge where the counter is 0, y is compared with TRUTH_TABLE[idx].
  - On mismatch: err_count increments. If first_fail_valid is 0, first_fail_idx <= idx and first_fail_valid <= 1.
  - If idx < 15: idx increments, {a,b,c,d} is updated to the new idx, and the counter is reloaded.
  - If idx == 15: state goes to DONE with busy=0 and done=1. a..d return to 0000 on the same edge.
- Latency: from the cycle after start acceptance to done high is exactly 16*(SETTLE_CYCLES+1) cycles.
- start in RUN is ignored, with no effect on idx, counters or results.
- start in DONE restarts the run, with the same behaviour as from IDLE.
- Simultaneous start with the final sample edge: the final sample completes and the block enters DONE; that start is ignored.
- err_count cannot exceed 16, so no wrap is possible. The 5-bit width is mandatory.
- Reset mid-run: the run is aborted immediately, all outputs go to their reset values, and partial results are discarded.
- Results in DONE remain stable regardless of y activity.

Decomposition:
- Shared package `bist4_pkg`:
  - state enum (IDLE, RUN, DONE);
  - VEC_N=16, IDX_W=4, ERR_W=5;
  - SETTLE_W=4.
- One natural sub-module: `settle_timer`. It is a loadable 4-bit down-counter with load, enable and zero outputs, used to pace vector hold time.

Test Plan:
- Golden DUT model y = TRUTH_TABLE[{a,b,c,d}] with TRUTH_TABLE=16'hA5F0 and SETTLE_CYCLES=0; pulse start -> busy for 16 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- Inverting DUT model (y = ~expected) with TRUTH_TABLE=16'hA5F0 -> done=1, pass=0, err_count=16, first_fail_idx=0.
- Single fault at vector 9 with SETTLE_CYCLES=3 -> done after 64 cycles, err_count=1, first_fail_idx=9, each vector held for exactly 4 cycles.
- start pulsed during RUN at vector 5 -> ignored; sequence continues to vector 15 and the total run length is unchanged.
- rst_n asserted while at vector 7 -> outputs 0 immediately, state IDLE, done=0. A subsequent start runs a full clean 16-vector pass.
- Restart from DONE after a failing run, with the DUT model fixed -> err_count cleared, new run gives pass=1.
